// File: rtl/muldiv_pkg.sv
// Shared types for the EX-stage RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int MD_XLEN  = 32;
    localparam int MD_CNT_W = $clog2(MD_XLEN);

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Handshake between the ID/EX pipeline registers and the multiply/divide unit.
interface ex_muldiv_unit_if #(parameter int XLEN = 32);

    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            flush;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, rs1_data, rs2_data, flush,
        input  stall, done, result
    );

    modport slave (
        input  start, funct3, rs1_data, rs2_data, flush,
        output stall, done, result
    );

endinterface

// File: rtl/ex_muldiv_unit_step.sv
// One iteration of the datapath: shift-add for multiply, restoring subtract for divide.
module md_step #(parameter int XLEN = 32) (
    input  logic            is_div,
    input  logic [XLEN:0]   acc,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN:0]   acc_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN-1:0] addend;
    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;

    // Multiply keeps acc below 2^XLEN, so add_sum never overflows its XLEN+1 bits.
    always_comb begin
        addend   = lo[0] ? opnd : '0;
        add_sum  = acc + {1'b0, addend};
        shifted  = {acc[XLEN-1:0], lo[XLEN-1]};
        diff     = {1'b0, shifted} - {2'b00, opnd};
        acc_next = {1'b0, add_sum[XLEN:1]};
        lo_next  = {add_sum[0], lo[XLEN-1:1]};
        if (is_div) begin
            if (diff[XLEN+1]) begin
                acc_next = shifted;
                lo_next  = {lo[XLEN-2:0], 1'b0};
            end else begin
                acc_next = diff[XLEN:0];
                lo_next  = {lo[XLEN-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage; stalls the front end until the result is ready.
// Define FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic          clk,
    input  logic          rst,
    ex_muldiv_unit_if.slave md
);

    md_state_e         state;
    md_op_e            op;
    logic [MD_CNT_W-1:0] counter;
    logic              sign_a;
    logic              sign_b;
    logic [XLEN-1:0]   opnd;
    logic [XLEN:0]     acc;
    logic [XLEN-1:0]   lo;
    logic              done_q;
    logic [XLEN-1:0]   result_q;

    md_op_e            op_in;
    logic              in_is_div;
    logic              in_sign_a;
    logic              in_sign_b;
    logic [XLEN-1:0]   in_mag_a;
    logic [XLEN-1:0]   in_mag_b;
    logic              div_by_zero;
    logic              div_ovf;
    logic              special_div;
    logic [XLEN-1:0]   special_result;

    logic [XLEN:0]     step_acc;
    logic [XLEN-1:0]   step_lo;
    logic [2*XLEN-1:0] prod_mag;
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   quot_signed;
    logic [XLEN-1:0]   rem_signed;
    logic [XLEN-1:0]   final_result;

    assign op_in       = md_op_e'(md.funct3);
    assign in_is_div   = md.funct3[2];
    assign in_sign_a   = md.rs1_data[XLEN-1] &
                         ((op_in == MULH) | (op_in == MULHSU) | (op_in == DIV) | (op_in == REM));
    assign in_sign_b   = md.rs2_data[XLEN-1] &
                         ((op_in == MULH) | (op_in == DIV) | (op_in == REM));
    assign in_mag_a    = in_sign_a ? -md.rs1_data : md.rs1_data;
    assign in_mag_b    = in_sign_b ? -md.rs2_data : md.rs2_data;
    assign div_by_zero = (md.rs2_data == '0);
    assign div_ovf     = ((op_in == DIV) | (op_in == REM)) &
                         (md.rs1_data == {1'b1, {(XLEN-1){1'b0}}}) & (md.rs2_data == '1);
    assign special_div = in_is_div & (div_by_zero | div_ovf);

    always_comb begin
        special_result = '0;
        if (op_in == DIV || op_in == DIVU)
            special_result = div_by_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
        else if (div_by_zero)
            special_result = md.rs1_data;
    end

`ifdef FAST_MUL_EN
    logic [2*XLEN-1:0] fast_mag;
    logic [2*XLEN-1:0] fast_prod;
    logic [XLEN-1:0]   fast_result;

    assign fast_mag    = {{XLEN{1'b0}}, in_mag_a} * {{XLEN{1'b0}}, in_mag_b};
    assign fast_prod   = (in_sign_a ^ in_sign_b) ? -fast_mag : fast_mag;
    assign fast_result = (op_in == MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif

    md_step #(.XLEN(XLEN)) u_step (
        .is_div   (op[2]),
        .acc      (acc),
        .lo       (lo),
        .opnd     (opnd),
        .acc_next (step_acc),
        .lo_next  (step_lo)
    );

    // The final iteration's outputs feed the fix-up directly so the result registers on the counter==0 edge.
    assign prod_mag    = {step_acc[XLEN-1:0], step_lo};
    assign prod_signed = (sign_a ^ sign_b) ? -prod_mag : prod_mag;
    assign quot_signed = (sign_a ^ sign_b) ? -step_lo : step_lo;
    assign rem_signed  = sign_a ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];

    always_comb begin
        case (op)
            MUL:                  final_result = prod_signed[XLEN-1:0];
            MULH, MULHSU, MULHU:  final_result = prod_signed[2*XLEN-1:XLEN];
            DIV, DIVU:            final_result = quot_signed;
            default:              final_result = rem_signed;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op       <= MUL;
            counter  <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
            lo       <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (md.flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (md.start) begin
                            op     <= op_in;
                            sign_a <= in_sign_a;
                            sign_b <= in_sign_b;
                            opnd   <= in_is_div ? in_mag_b : in_mag_a;
                            lo     <= in_is_div ? in_mag_a : in_mag_b;
                            acc    <= '0;
                            if (special_div) begin
                                result_q <= special_result;
                                done_q   <= 1'b1;
                                state    <= DONE;
                            end
`ifdef FAST_MUL_EN
                            else if (!in_is_div) begin
                                result_q <= fast_result;
                                done_q   <= 1'b1;
                                state    <= DONE;
                            end
`endif
                            else begin
                                counter <= MD_CNT_W'(XLEN-1);
                                state   <= BUSY;
                            end
                        end
                    end
                    BUSY: begin
                        acc     <= step_acc;
                        lo      <= step_lo;
                        counter <= counter - MD_CNT_W'(1);
                        if (counter == '0) begin
                            result_q <= final_result;
                            done_q   <= 1'b1;
                            state    <= DONE;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign md.stall  = ((state == IDLE) & md.start & ~md.flush) | (state == BUSY);
    assign md.done   = done_q;
    assign md.result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized self-checking bench for ex_muldiv_unit against a 64-bit arithmetic reference model.
module tb_ex_muldiv_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    int          exp_from = 1;
    int          exp_to   = 0;
    int          exp_done = -1;
    logic [31:0] exp_result = '0;
    logic [31:0] res;

    ex_muldiv_unit_if #(.XLEN(32)) md ();

    ex_muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .md  (md.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
    endtask

    // Reference semantics straight from the ISA definition, using wide signed/unsigned arithmetic.
    function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int opLatency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
`ifdef FAST_MUL_EN
        if (!f[2]) return 1;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Every cycle: stall must cover exactly the expected window and done must pulse once with the model's value.
    always @(negedge clk) begin
        checkOutput("stall", {31'b0, md.stall}, {31'b0, (cyc >= exp_from && cyc <= exp_to)});
        checkOutput("done", {31'b0, md.done}, {31'b0, (cyc == exp_done)});
        if (cyc == exp_done) checkOutput("result", md.result, exp_result);
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after the op completes or is aborted.
    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input int flush_at, input int rst_at, input bit keep_start,
                                 output logic [31:0] r);
        int lat;
        int t0;
        lat = opLatency(f, a, b);
        t0  = cyc;
        r   = 'x;
        md.start    = 1'b1;
        md.funct3   = f;
        md.rs1_data = a;
        md.rs2_data = b;
        md.flush    = (flush_at == 0);
        exp_result  = refModel(f, a, b);
        exp_from    = t0;
        exp_to      = t0 + lat - 1;
        exp_done    = t0 + lat;
        if (flush_at >= 0) begin
            exp_to   = (flush_at == 0) ? t0 - 1 : t0 + flush_at;
            exp_done = -1;
        end
        if (rst_at > 0) begin
            exp_to   = t0 + rst_at - 1;
            exp_done = -1;
        end
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            md.rs1_data = $urandom;
            md.rs2_data = $urandom;
            md.funct3   = 3'($urandom_range(0, 7));
            if (flush_at >= 0 && k == flush_at) md.flush = 1'b1;
            if (flush_at >= 0 && k == flush_at + 1) begin
                md.flush = 1'b0;
                md.start = 1'b0;
                return;
            end
            if (rst_at > 0 && k == rst_at) begin
                md.start = 1'b0;
                #1 rst = 1'b1;
                #1;
                checkOutput("rst_stall", {31'b0, md.stall}, 32'h0);
                checkOutput("rst_done", {31'b0, md.done}, 32'h0);
                checkOutput("rst_result", md.result, 32'h0);
                repeat (2) @(posedge clk);
                #3 rst = 1'b0;
                @(posedge clk); #1;
                return;
            end
            if (k == lat) begin
                r = md.result;
                if (!keep_start) md.start = 1'b0;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic runLiteral(input string name, input logic [2:0] f, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] expv);
        applyStimulus(f, a, b, -1, -1, 1'b0, res);
        checkOutput(name, res, expv);
    endtask

    initial begin
        md.start    = 1'b0;
        md.funct3   = 3'd0;
        md.rs1_data = '0;
        md.rs2_data = '0;
        md.flush    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_stall", {31'b0, md.stall}, 32'h0);
        checkOutput("reset_done", {31'b0, md.done}, 32'h0);
        checkOutput("reset_result", md.result, 32'h0);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        runLiteral("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        runLiteral("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        runLiteral("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        runLiteral("mulhsu_-1x2", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        runLiteral("div_-7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        runLiteral("rem_-7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        runLiteral("divu_100/7", 3'd5, 32'd100, 32'd7, 32'd14);
        runLiteral("remu_100/7", 3'd7, 32'd100, 32'd7, 32'd2);
        runLiteral("divu_5/0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
        runLiteral("rem_5/0", 3'd6, 32'd5, 32'd0, 32'd5);
        runLiteral("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        runLiteral("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

        // Flush mid-divide, then flush competing with start in IDLE.
        applyStimulus(3'd4, 32'd1000, 32'd3, 10, -1, 1'b0, res);
        @(posedge clk); #1;
        applyStimulus(3'd0, 32'd9, 32'd9, 0, -1, 1'b0, res);
        @(posedge clk); #1;

        // Start held through the done cycle: ignored there, then restarts the next cycle.
        applyStimulus(3'd0, 32'd5, 32'd6, -1, -1, 1'b1, res);
        checkOutput("b2b_first", res, 32'd30);
        runLiteral("b2b_second", 3'd5, 32'd50, 32'd8, 32'd6);

        // Asynchronous reset in the middle of an iterative multiply.
        applyStimulus(3'd0, 32'd1234, 32'd5678, -1, 5, 1'b0, res);
        runLiteral("mul_3x4_after_rst", 3'd0, 32'd3, 32'd4, 32'd12);

        for (int i = 0; i < 24; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), pickOperand(), pickOperand(), -1, -1,
                          1'($urandom_range(0, 1)), res);
            if (!md.start) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        md.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
